// File: rtl/RS5_pkg.sv
// Shared vector-unit types: element width, group multiplier and the
// element sequencer state encoding.
package RS5_pkg;

   typedef enum logic [1:0] {
      EW8  = 2'b00,
      EW16 = 2'b01,
      EW32 = 2'b10,
      EW64 = 2'b11
   } vew_e;

   // Fractional multipliers share the upper encoding half, as in vtype.vlmul.
   typedef enum logic [2:0] {
      LMUL_1   = 3'b000,
      LMUL_2   = 3'b001,
      LMUL_4   = 3'b010,
      LMUL_8   = 3'b011,
      LMUL_1_8 = 3'b101,
      LMUL_1_4 = 3'b110,
      LMUL_1_2 = 3'b111
   } vlmul_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_e;

endpackage

// File: rtl/vector_elem_sequencer.sv
// Splits one vector instruction into per-register beats with byte enables,
// honouring downstream backpressure and pulsing done/illegal on completion.
module vector_elem_sequencer
   import RS5_pkg::*;
#(
   parameter int VLEN  = 64,
   parameter int VLENB = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start_i,
   input  vew_e                    vsew_i,
   input  vlmul_e                  vlmul_i,
   input  logic [$bits(VLEN)-1:0]  vl_i,
   input  logic                    vill_i,
   input  logic                    ready_i,
   output logic                    valid_o,
   output logic [2:0]              reg_offset_o,
   output logic [VLENB-1:0]        byte_en_o,
   output logic                    first_o,
   output logic                    last_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    illegal_o
);

   localparam int VL_W    = $bits(VLEN);
   localparam int GRP_MAX = VLENB * 8;
   localparam int RW      = $clog2(GRP_MAX + 1);

   function automatic logic [RW-1:0] group_bytes(input vlmul_e lmul);
      logic [RW-1:0] g;
      case (lmul)
         LMUL_2:  g = RW'(VLENB * 2);
         LMUL_4:  g = RW'(VLENB * 4);
         LMUL_8:  g = RW'(VLENB * 8);
         default: g = RW'(VLENB);
      endcase
      return g;
   endfunction

   // vl << sew can far exceed the group, so compare at full width before narrowing.
   function automatic logic [RW-1:0] clamp_total(input logic [VL_W-1:0] vl,
                                                  input vew_e           sew,
                                                  input logic [RW-1:0]  grp);
      logic [VL_W+3:0] tot;
      logic [VL_W+3:0] grp_w;
      tot   = {4'b0000, vl} << sew;
      grp_w = {{(VL_W+4-RW){1'b0}}, grp};
      return (tot > grp_w) ? grp : tot[RW-1:0];
   endfunction

   function automatic logic [VLENB-1:0] byte_mask(input logic [RW-1:0] rem);
      logic [VLENB-1:0] m;
      m = '0;
      if (rem >= RW'(VLENB)) begin
         m = '1;
      end else begin
         for (int i = 0; i < VLENB; i++) begin
            if (RW'(i) < rem) m[i] = 1'b1;
         end
      end
      return m;
   endfunction

   function automatic logic [RW-1:0] sat_sub(input logic [RW-1:0] rem);
      return (rem > RW'(VLENB)) ? rem - RW'(VLENB) : '0;
   endfunction

   seq_state_e       state_q, state_d;

   logic             vld_p1,   vld_d;
   logic [2:0]       off_p1,   off_d;
   logic [RW-1:0]    rem_p1,   rem_d;
   logic [VLENB-1:0] be_p1,    be_d;
   logic             first_p1, first_d;
   logic             last_p1,  last_d;
   logic             busy_p1,  busy_d;
   logic             done_p1,  done_d;
   logic             ill_p1,   ill_d;

   logic             accept;
   logic             beat_fire;
   logic [RW-1:0]    tot_acc;
   logic             empty_acc;
   logic [RW-1:0]    rem_nxt;

   // A pending done pulse blocks acceptance so back-to-back starts see a gap.
   assign accept    = (state_q == IDLE) && start_i && !done_p1;
   assign beat_fire = vld_p1 && ready_i;
   assign tot_acc   = clamp_total(vl_i, vsew_i, group_bytes(vlmul_i));
   assign empty_acc = vill_i || (tot_acc == '0);
   assign rem_nxt   = sat_sub(rem_p1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && !empty_acc) state_d = RUN;
         RUN:     if (beat_fire && last_p1) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      vld_d   = vld_p1;
      off_d   = off_p1;
      rem_d   = rem_p1;
      be_d    = be_p1;
      first_d = first_p1;
      last_d  = last_p1;
      done_d  = 1'b0;
      ill_d   = 1'b0;
      busy_d  = accept ? 1'b1 : (done_p1 ? 1'b0 : busy_p1);

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (empty_acc) begin
                  vld_d   = 1'b0;
                  off_d   = '0;
                  rem_d   = '0;
                  be_d    = '0;
                  first_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
                  ill_d   = vill_i;
               end else begin
                  vld_d   = 1'b1;
                  off_d   = '0;
                  rem_d   = tot_acc;
                  be_d    = byte_mask(tot_acc);
                  first_d = 1'b1;
                  last_d  = (tot_acc <= RW'(VLENB));
               end
            end
         end
         RUN: begin
            if (beat_fire) begin
               if (last_p1) begin
                  vld_d   = 1'b0;
                  off_d   = '0;
                  rem_d   = '0;
                  be_d    = '0;
                  first_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  off_d   = off_p1 + 3'd1;
                  rem_d   = rem_nxt;
                  be_d    = byte_mask(rem_nxt);
                  first_d = 1'b0;
                  last_d  = (rem_nxt <= RW'(VLENB));
               end
            end
         end
         default: ;
      endcase
   end

   // ---- output register stage ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1   <= 1'b0;
         off_p1   <= '0;
         rem_p1   <= '0;
         be_p1    <= '0;
         first_p1 <= 1'b0;
         last_p1  <= 1'b0;
         busy_p1  <= 1'b0;
         done_p1  <= 1'b0;
         ill_p1   <= 1'b0;
      end else begin
         vld_p1   <= vld_d;
         off_p1   <= off_d;
         rem_p1   <= rem_d;
         be_p1    <= be_d;
         first_p1 <= first_d;
         last_p1  <= last_d;
         busy_p1  <= busy_d;
         done_p1  <= done_d;
         ill_p1   <= ill_d;
      end
   end

   assign valid_o      = vld_p1;
   assign reg_offset_o = off_p1;
   assign byte_en_o    = be_p1;
   assign first_o      = first_p1;
   assign last_o       = last_p1;
   assign busy_o       = busy_p1;
   assign done_o       = done_p1;
   assign illegal_o    = ill_p1;

endmodule

// File: tb/tb_vector_elem_sequencer.sv
// Directed and randomized bench for vector_elem_sequencer; expected beats are
// derived from byte counts, independent of the design's internal structure.
module tb_vector_elem_sequencer;
   import RS5_pkg::*;

   localparam int VLEN  = 64;
   localparam int VLENB = 8;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start_i;
   vew_e             vsew_i;
   vlmul_e           vlmul_i;
   logic [31:0]      vl_i;
   logic             vill_i;
   logic             ready_i;
   logic             valid_o;
   logic [2:0]       reg_offset_o;
   logic [VLENB-1:0] byte_en_o;
   logic             first_o;
   logic             last_o;
   logic             busy_o;
   logic             done_o;
   logic             illegal_o;

   int n_chk  = 0;
   int n_pass = 0;

   vector_elem_sequencer #(.VLEN(VLEN), .VLENB(VLENB)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start_i      (start_i),
      .vsew_i       (vsew_i),
      .vlmul_i      (vlmul_i),
      .vl_i         (vl_i),
      .vill_i       (vill_i),
      .ready_i      (ready_i),
      .valid_o      (valid_o),
      .reg_offset_o (reg_offset_o),
      .byte_en_o    (byte_en_o),
      .first_o      (first_o),
      .last_o       (last_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .illegal_o    (illegal_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_total(input vew_e s, input vlmul_e l, input int vl);
      longint t;
      int     g;
      t = longint'(vl) * (longint'(1) << int'(s));
      case (l)
         LMUL_2:  g = VLENB * 2;
         LMUL_4:  g = VLENB * 4;
         LMUL_8:  g = VLENB * 8;
         default: g = VLENB;
      endcase
      return (t > longint'(g)) ? g : int'(t);
   endfunction

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_valid"}, valid_o, 0);
      chk({tag, "_off"},   reg_offset_o, 0);
      chk({tag, "_be"},    byte_en_o, 0);
      chk({tag, "_first"}, first_o, 0);
      chk({tag, "_last"},  last_o, 0);
   endtask

   // Called one cycle after the accepting edge; walks beats through done+1.
   task automatic expect_seq(input int total, input bit vill, input int mode);
      int               nb, k, cyc, rem, be_int;
      bit               rdy;
      logic [VLENB-1:0] be;
      nb = vill ? 0 : (total + VLENB - 1) / VLENB;
      if (nb == 0) begin
         chk_idle_zero("empty");
         chk("empty_done", done_o, 1);
         chk("empty_ill",  illegal_o, vill);
         chk("empty_busy", busy_o, 1);
         step();
         chk("empty_done_end", done_o, 0);
         chk("empty_ill_end",  illegal_o, 0);
         chk("empty_busy_end", busy_o, 0);
         chk("empty_valid_end", valid_o, 0);
         return;
      end
      k   = 0;
      cyc = 0;
      while (k < nb && cyc < 400) begin
         rem    = total - k * VLENB;
         be_int = (rem >= VLENB) ? ((1 << VLENB) - 1) : ((1 << rem) - 1);
         be     = be_int[VLENB-1:0];
         chk("beat_valid", valid_o, 1);
         chk("beat_off",   reg_offset_o, k);
         chk("beat_be",    byte_en_o, be);
         chk("beat_first", first_o, (k == 0));
         chk("beat_last",  last_o, (k == nb - 1));
         chk("beat_busy",  busy_o, 1);
         chk("beat_done",  done_o, 0);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2) == 1;
            default: rdy = $urandom_range(0, 1) == 1;
         endcase
         ready_i = rdy;
         step();
         cyc++;
         if (rdy) k++;
      end
      if (k < nb) chk("beat_timeout", k, nb);
      ready_i = 1'b0;
      chk_idle_zero("done");
      chk("done_pulse", done_o, 1);
      chk("done_busy",  busy_o, 1);
      chk("done_ill",   illegal_o, 0);
      step();
      chk("post_done",  done_o, 0);
      chk("post_busy",  busy_o, 0);
      chk("post_valid", valid_o, 0);
   endtask

   task automatic run_instr(input vew_e s, input vlmul_e l, input int vl,
                            input bit vill, input int mode);
      start_i = 1'b1;
      vsew_i  = s;
      vlmul_i = l;
      vl_i    = vl;
      vill_i  = vill;
      step();
      start_i = 1'b0;
      vill_i  = 1'b0;
      vl_i    = $urandom;
      expect_seq(model_total(s, l, vl), vill, mode);
   endtask

   initial begin
      vlmul_e lm_tab[7] = '{LMUL_1, LMUL_2, LMUL_4, LMUL_8, LMUL_1_8, LMUL_1_4, LMUL_1_2};
      vew_e   s;
      vlmul_e l;
      int     vl;
      bit     vill;

      reset_n = 1'b0;
      start_i = 1'b0;
      vsew_i  = EW8;
      vlmul_i = LMUL_1;
      vl_i    = '0;
      vill_i  = 1'b0;
      ready_i = 1'b0;
      repeat (3) step();
      chk_idle_zero("rst");
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_ill",  illegal_o, 0);
      reset_n = 1'b1;
      step();

      // Two beats: 12 bytes in a 16-byte group.
      run_instr(EW32, LMUL_2, 3, 1'b0, 0);

      // Eight full beats with ready toggling.
      run_instr(EW8, LMUL_8, 64, 1'b0, 1);

      // Zero length then illegal configuration.
      run_instr(EW8, LMUL_1, 0, 1'b0, 0);
      run_instr(EW32, LMUL_4, 5, 1'b1, 0);

      // Fractional group, single partial beat.
      run_instr(EW16, LMUL_1_2, 2, 1'b0, 0);

      // Clamp: requested bytes exceed the group.
      run_instr(EW64, LMUL_2, 40, 1'b0, 2);

      // Asynchronous reset in the middle of an eight-beat instruction.
      start_i = 1'b1;
      vsew_i  = EW8;
      vlmul_i = LMUL_8;
      vl_i    = 64;
      step();
      start_i = 1'b0;
      ready_i = 1'b1;
      step();
      step();
      chk("pre_rst_off", reg_offset_o, 2);
      #2 reset_n = 1'b0;
      #1;
      chk_idle_zero("midrst");
      chk("midrst_busy", busy_o, 0);
      chk("midrst_done", done_o, 0);
      ready_i = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      chk("after_rst_valid", valid_o, 0);
      chk("after_rst_busy",  busy_o, 0);
      run_instr(EW8, LMUL_8, 64, 1'b0, 0);

      // start_i held high across an instruction and its done cycle.
      start_i = 1'b1;
      vsew_i  = EW32;
      vlmul_i = LMUL_2;
      vl_i    = 3;
      step();
      expect_seq(12, 1'b0, 0);
      step();
      start_i = 1'b0;
      expect_seq(12, 1'b0, 0);

      // Randomized configurations and backpressure.
      for (int i = 0; i < 12; i++) begin
         s    = vew_e'($urandom_range(0, 3));
         l    = lm_tab[$urandom_range(0, 6)];
         vl   = $urandom_range(0, 70);
         vill = ($urandom_range(0, 7) == 0);
         run_instr(s, l, vl, vill, 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
